// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared encodings, geometry and byte-lane helpers for the data cache.
package data_cache_pkg;
  localparam int INDEX_WIDTH = 4;
  localparam int TAG_WIDTH = 32 - 2 - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_BYTE = 2'b01;
  localparam logic [1:0] ACC_HALF = 2'b10;
  localparam logic [1:0] ACC_WORD = 2'b11;
  localparam logic [1:0] IO_WINDOW = 2'b11;
  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, DONE} cacheState;
  function automatic logic [1:0] lastByte(input logic [1:0] acc);
    return acc == ACC_WORD ? 2'd3 : acc == ACC_HALF ? 2'd1 : 2'd0;
  endfunction
  function automatic logic isIo(input logic [31:0] addr);
    return addr[17:16] == IO_WINDOW;
  endfunction
  // Zero-extended byte/half/word taken from byte offset off of a little-endian word.
  function automatic logic [31:0] extractField(input logic [31:0] word, input logic [1:0] off, input logic [1:0] last);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    return last == 2'd3 ? s : last == 2'd1 ? {16'h0, s[15:0]} : {24'h0, s[7:0]};
  endfunction
  function automatic logic [3:0] byteEnable(input logic [1:0] off, input logic [1:0] last);
    return (last == 2'd3 ? 4'hF : last == 2'd1 ? 4'h3 : 4'h1) << off;
  endfunction
endpackage

// File: rtl/data_cache_array.sv
// data_cache_array: direct-mapped valid/tag/data store with combinational lookup and a byte-enable write port.
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic [INDEX_WIDTH-1:0] lookupIndex,
  input  logic [TAG_WIDTH-1:0]   lookupTag,
  output logic                   hit,
  output logic [31:0]            lineData,
  input  logic                   writeEn,
  input  logic                   fillEn,
  input  logic [INDEX_WIDTH-1:0] writeIndex,
  input  logic [TAG_WIDTH-1:0]   writeTag,
  input  logic [3:0]             writeMask,
  input  logic [31:0]            writeData
);
  logic [LINES-1:0] valid;
  logic [TAG_WIDTH-1:0] tags [LINES];
  logic [31:0] lines [LINES];
  assign hit = valid[lookupIndex] && tags[lookupIndex] == lookupTag;
  assign lineData = lines[lookupIndex];
  always_ff @(posedge clockIn or negedge resetIn)
    if (!resetIn) valid <= '0;
    else if (writeEn && fillEn) valid[writeIndex] <= 1'b1;
  // Only the valid bits need reset; tag and data are qualified by them.
  always_ff @(posedge clockIn) begin
    if (writeEn && fillEn) tags[writeIndex] <= writeTag;
    for (int b = 0; b < 4; b++)
      if (writeEn && writeMask[b]) lines[writeIndex][8*b +: 8] <= writeData[8*b +: 8];
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: write-through, no-write-allocate load cache that serialises misses, stores and IO onto the byte bus.
module data_cache
  import data_cache_pkg::*;
(
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic [1:0]  accessType,
  input  logic        readWriteIn,
  input  logic [31:0] dataAddr,
  input  logic [31:0] dataIn,
  output logic        dataValid,
  output logic [31:0] dataOut,
  output logic        dataWriteSuc,
  output logic        memReq,
  input  logic        memGrant,
  output logic [31:0] memAddr,
  output logic        memWrite,
  output logic [7:0]  memDataOut,
  input  logic [7:0]  memDataIn,
  input  logic        ioBufferFull
);
  cacheState state, nextState;
  logic [31:0] addrQ, dataQ, wordBuf, wordNext, lineData, cacheWriteAddr, cacheWriteData;
  logic [1:0] sizeQ, lastQ, byteCnt, captIdx;
  logic [3:0] cacheMask;
  logic ioQ, issuedAll, captPending, hit, request, issue, lastCapture, cacheWrite, cacheFill;
  assign request = state == IDLE && accessType != ACC_NONE;
  assign issue = memReq && memGrant;
  assign lastCapture = state == RD_MEM && captPending && captIdx == lastQ;
  always_comb begin
    wordNext = wordBuf;
    wordNext[{captIdx, 3'b000} +: 8] = memDataIn;
  end
  always_ff @(posedge clockIn or negedge resetIn)
    if (!resetIn) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = state == IDLE ? (!request ? IDLE : !readWriteIn ? WR_MEM : (isIo(dataAddr) || !hit) ? RD_MEM : IDLE)
              : state == RD_MEM ? (lastCapture ? DONE : RD_MEM)
              : state == WR_MEM ? ((issue && byteCnt == lastQ) ? IDLE : WR_MEM)
              : IDLE;
  // Cacheable misses fetch the whole aligned word; IO reads and all writes walk from the access address.
  always_comb begin
    memReq = state == RD_MEM ? !issuedAll : state == WR_MEM ? !(ioQ && ioBufferFull) : 1'b0;
    memWrite = memReq && state == WR_MEM;
    memAddr = memReq ? ((state == RD_MEM && !ioQ) ? {addrQ[31:2], 2'b00} : addrQ) + {30'd0, byteCnt} : '0;
    memDataOut = memWrite ? dataQ[{byteCnt, 3'b000} +: 8] : '0;
  end
  always_comb begin
    cacheFill = lastCapture && !ioQ;
    cacheWrite = cacheFill || (request && !readWriteIn && !isIo(dataAddr) && hit);
    cacheWriteAddr = cacheFill ? addrQ : dataAddr;
    cacheMask = cacheFill ? 4'hF : byteEnable(dataAddr[1:0], lastByte(accessType));
    cacheWriteData = cacheFill ? wordNext : dataIn << {dataAddr[1:0], 3'b000};
  end
  always_ff @(posedge clockIn or negedge resetIn)
    if (!resetIn) begin
      addrQ <= '0;
      dataQ <= '0;
      sizeQ <= '0;
      lastQ <= '0;
      ioQ <= 1'b0;
      byteCnt <= '0;
      captIdx <= '0;
      issuedAll <= 1'b0;
      captPending <= 1'b0;
      wordBuf <= '0;
      dataValid <= 1'b0;
      dataOut <= '0;
      dataWriteSuc <= 1'b0;
    end else begin
      dataValid <= 1'b0;
      dataWriteSuc <= 1'b0;
      captPending <= 1'b0;
      if (request) begin
        addrQ <= dataAddr;
        dataQ <= dataIn;
        sizeQ <= lastByte(accessType);
        lastQ <= (readWriteIn && !isIo(dataAddr)) ? 2'd3 : lastByte(accessType);
        ioQ <= isIo(dataAddr);
        byteCnt <= '0;
        issuedAll <= 1'b0;
        wordBuf <= '0;
        if (readWriteIn && !isIo(dataAddr) && hit) begin
          dataValid <= 1'b1;
          dataOut <= extractField(lineData, dataAddr[1:0], lastByte(accessType));
        end
      end
      // Counter holds on ungranted cycles and parks at the last byte instead of wrapping.
      if (issue) begin
        captPending <= state == RD_MEM;
        captIdx <= byteCnt;
        if (byteCnt == lastQ) issuedAll <= 1'b1;
        else byteCnt <= byteCnt + 2'd1;
      end
      if (captPending) wordBuf <= wordNext;
      if (lastCapture) begin
        dataValid <= 1'b1;
        dataOut <= extractField(wordNext, ioQ ? 2'b00 : addrQ[1:0], sizeQ);
      end
      if (state == WR_MEM && issue && byteCnt == lastQ) dataWriteSuc <= 1'b1;
    end
  data_cache_array array (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .lookupIndex(dataAddr[2 +: INDEX_WIDTH]),
    .lookupTag(dataAddr[31 -: TAG_WIDTH]),
    .hit(hit),
    .lineData(lineData),
    .writeEn(cacheWrite),
    .fillEn(cacheFill),
    .writeIndex(cacheWriteAddr[2 +: INDEX_WIDTH]),
    .writeTag(cacheWriteAddr[31 -: TAG_WIDTH]),
    .writeMask(cacheMask),
    .writeData(cacheWriteData)
  );
endmodule
